boid_plotter: RTL and testbench

BOID_PLOTTER -- requirements
Module: boid_plotter

---
 rtl/boid_plotter.sv | 166 ++++++++++++++++
 tb/tb_boid_plotter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_plotter.sv
// boid_plotter
//   Erases each boid's previous 2x2 sprite and draws it at its new position
//   in an external frame buffer, one pixel write per cycle.
//   Every accepted position takes a fixed 10-cycle slot:
//     1 IDLE (accept), 4 ERASE, 4 DRAW, 1 DONE.
//
// Ports
//   clk, reset      : clock; asynchronous active-high reset
//   in_valid/ready  : position handshake (in_ready high only when idle)
//   boid_id         : boid index; ids >= NUM_BOIDS produce no writes
//   x_in, y_in      : signed fixed point, 16 fractional bits
//   m10k_waddr/wdata/we : registered frame-buffer write port
//   done            : one-cycle pulse in the last cycle of each slot
module boid_plotter #(
  parameter int          NUM_BOIDS = 2,
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter logic [7:0]  FG_COLOR  = 8'hFF,
  parameter logic [7:0]  BG_COLOR  = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(NUM_BOIDS):0]   boid_id,
  input  logic [27:0]                  x_in,
  input  logic [26:0]                  y_in,
  output logic [18:0]                  m10k_waddr,
  output logic [7:0]                   m10k_wdata,
  output logic                         m10k_we,
  output logic                         done
);

  localparam int IDW = $clog2(NUM_BOIDS) + 1;
  localparam int TW  = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1;
  localparam logic [IDW-1:0] NB = IDW'(NUM_BOIDS);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [11:0]     px_q, px_d;
  logic [10:0]     py_q, py_d;
  logic [18:0]     waddr_q, waddr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            done_q, done_d;

  // Per-boid previous-position table
  logic [11:0]          old_px [NUM_BOIDS];
  logic [10:0]          old_py [NUM_BOIDS];
  logic [NUM_BOIDS-1:0] old_valid;

  logic            cur_id_ok, id_ok_d, write_phase, in_range;
  logic [TW-1:0]   rd_idx;
  logic [11:0]     base_x;
  logic [10:0]     base_y;
  logic [12:0]     sx;
  logic [11:0]     sy;

  assign cur_id_ok = (id_q < NB);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    id_d    = id_q;
    px_d    = px_q;
    py_d    = py_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = ERASE;
        step_d  = 2'd0;
        id_d    = boid_id;
        px_d    = x_in[27:16];
        py_d    = y_in[26:16];
      end
      ERASE: begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = DRAW;
      end
      DRAW: begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // The write port is registered, so the pixel for the *next* cycle is
    // computed from next-state values; this lets the first ERASE strobe
    // appear in the cycle straight after the accepting edge.
    id_ok_d     = (id_d < NB);
    rd_idx      = id_ok_d ? id_d[TW-1:0] : '0;
    write_phase = (state_d == ERASE) || (state_d == DRAW);
    base_x      = (state_d == ERASE) ? old_px[rd_idx] : px_d;
    base_y      = (state_d == ERASE) ? old_py[rd_idx] : py_d;
    // step bit 0 = dx, bit 1 = dy: visits (0,0),(1,0),(0,1),(1,1)
    sx = {base_x[11], base_x} + {12'd0, step_d[0]};
    sy = {base_y[10], base_y} + {11'd0, step_d[1]};
    in_range = !sx[12] && ({1'b0, sx[11:0]} < 13'(H_RES)) &&
               !sy[11] && ({1'b0, sy[10:0]} < 12'(V_RES));

    we_d    = write_phase && in_range && id_ok_d &&
              ((state_d == DRAW) || old_valid[rd_idx]);
    waddr_d = write_phase ? (19'(sy[10:0]) * 19'(H_RES) + 19'(sx[11:0]))
                          : waddr_q;
    wdata_d = write_phase ? ((state_d == ERASE) ? BG_COLOR : FG_COLOR)
                          : wdata_q;
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      id_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      id_q    <= id_d;
      px_q    <= px_d;
      py_q    <= py_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  // Table entries commit at the end of the DONE cycle, so an aborted plot
  // never leaves a half-updated entry behind.
  for (genvar gi = 0; gi < NUM_BOIDS; gi++) begin : g_tbl
    logic [11:0] opx_q;
    logic [10:0] opy_q;
    logic        ov_q;
    logic        upd;
    assign upd = (state_q == DONE) && cur_id_ok && (id_q == IDW'(gi));
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        opx_q <= '0;
        opy_q <= '0;
        ov_q  <= 1'b0;
      end else if (upd) begin
        opx_q <= px_q;
        opy_q <= py_q;
        ov_q  <= 1'b1;
      end
    end
    assign old_px[gi]    = opx_q;
    assign old_py[gi]    = opy_q;
    assign old_valid[gi] = ov_q;
  end

  assign in_ready   = (state_q == IDLE);
  assign m10k_waddr = waddr_q;
  assign m10k_wdata = wdata_q;
  assign m10k_we    = we_q;
  assign done       = done_q;

endmodule

// File: tb/tb_boid_plotter.sv
module tb_boid_plotter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  boid_id = '0;
  logic [27:0] x_in = '0;
  logic [26:0] y_in = '0;
  logic [18:0] m10k_waddr;
  logic [7:0]  m10k_wdata;
  logic        m10k_we;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  boid_plotter #(.NUM_BOIDS(2), .H_RES(640), .V_RES(480),
                 .FG_COLOR(8'hFF), .BG_COLOR(8'h00)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .boid_id(boid_id), .x_in(x_in), .y_in(y_in),
    .m10k_waddr(m10k_waddr), .m10k_wdata(m10k_wdata),
    .m10k_we(m10k_we), .done(done));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-cycle expectation queue ----------
  typedef struct {
    logic we; int addr; int data; logic dn;
    logic upd; int id; int px; int py;
  } exp_t;

  exp_t q[$];
  int   m_px[4];
  int   m_py[4];
  logic m_valid[4] = '{default: 1'b0};
  exp_t e_cur;
  bit   idle_now;

  function automatic bit on_screen(int x, int y);
    return (x >= 0) && (x < 640) && (y >= 0) && (y < 480);
  endfunction

  task automatic model_accept(input int id, input logic [27:0] x, input logic [26:0] y);
    int px, py;
    exp_t e;
    px = $signed(x) >>> 16;
    py = $signed(y) >>> 16;
    for (int i = 0; i < 4; i++) begin
      e = '{default: 0};
      if (id < 2 && m_valid[id]) begin
        e.we   = on_screen(m_px[id] + i % 2, m_py[id] + i / 2);
        e.addr = (m_py[id] + i / 2) * 640 + m_px[id] + i % 2;
      end
      e.data = 0;
      q.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      e = '{default: 0};
      e.we   = (id < 2) && on_screen(px + i % 2, py + i / 2);
      e.addr = (py + i / 2) * 640 + px + i % 2;
      e.data = 255;
      q.push_back(e);
    end
    e = '{default: 0};
    e.dn = 1'b1; e.upd = (id < 2); e.id = id; e.px = px; e.py = py;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      chk("rst_we", m10k_we, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_waddr", m10k_waddr, 0);
      chk("rst_wdata", m10k_wdata, 0);
    end else begin
      idle_now = (q.size() == 0);
      e_cur = '{default: 0};
      if (!idle_now) e_cur = q.pop_front();
      chk("m_ready", in_ready, idle_now);
      chk("m_we", m10k_we, e_cur.we);
      chk("m_done", done, e_cur.dn);
      if (e_cur.we) begin
        chk("m_addr", m10k_waddr, e_cur.addr);
        chk("m_data", m10k_wdata, e_cur.data);
      end
      if (e_cur.upd) begin
        m_px[e_cur.id] = e_cur.px; m_py[e_cur.id] = e_cur.py; m_valid[e_cur.id] = 1'b1;
      end
      if (idle_now && in_valid) model_accept(int'(boid_id), x_in, y_in);
    end
  end

  // ---------------- directed vectors ---------------------------------------
  typedef struct {
    int id; logic [27:0] x; logic [26:0] y;
    logic [3:0] ew; int ea[4];
    logic [3:0] dw; int da[4];
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input string tag);
    int nw;
    nw = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; boid_id = 2'(v.id); x_in = v.x; y_in = v.y;
    @(negedge clk);
    chk({tag, "_ready_k"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk({tag, "_erase_we"}, m10k_we, v.ew[c-1]);
        if (v.ew[c-1]) begin
          chk({tag, "_erase_addr"}, m10k_waddr, v.ea[c-1]);
          chk({tag, "_erase_data"}, m10k_wdata, 8'h00);
        end
      end else if (c <= 8) begin
        chk({tag, "_draw_we"}, m10k_we, v.dw[c-5]);
        if (v.dw[c-5]) begin
          chk({tag, "_draw_addr"}, m10k_waddr, v.da[c-5]);
          chk({tag, "_draw_data"}, m10k_wdata, 8'hFF);
        end
      end else begin
        chk({tag, "_we_done_cyc"}, m10k_we, 0);
      end
      chk({tag, "_done"}, done, (c == 9));
      if (m10k_we) nw++;
    end
    @(negedge clk);
    chk({tag, "_ready_k10"}, in_ready, 1);
    $display("plot %s: id=%0d x=%h y=%h writes=%0d", tag, v.id, v.x, v.y, nw);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic int pick(int lim);
    int r;
    r = int'($urandom_range(0, 5));
    case (r)
      0: return -1 - int'($urandom_range(0, 1));
      1: return lim - 1 + int'($urandom_range(0, 1));
      default: return int'($urandom_range(0, lim - 1));
    endcase
  endfunction

  initial begin
    int last, npulse, rx, ry;

    vecs[0] = '{id: 0, x: 28'h00A0000, y: 27'h0140000,
                ew: 4'b0000, ea: '{0, 0, 0, 0},
                dw: 4'b1111, da: '{12810, 12811, 13450, 13451}};
    vecs[1] = '{id: 0, x: 28'h00B0000, y: 27'h0140000,
                ew: 4'b1111, ea: '{12810, 12811, 13450, 13451},
                dw: 4'b1111, da: '{12811, 12812, 13451, 13452}};
    vecs[2] = '{id: 1, x: 28'h27F0000, y: 27'h1DF0000,
                ew: 4'b0000, ea: '{0, 0, 0, 0},
                dw: 4'b0001, da: '{307199, 0, 0, 0}};
    vecs[3] = '{id: 1, x: 28'hFFF0000, y: 27'h0140000,
                ew: 4'b0001, ea: '{307199, 0, 0, 0},
                dw: 4'b1010, da: '{0, 12800, 0, 13440}};
    vecs[4] = '{id: 2, x: 28'h0050000, y: 27'h0050000,
                ew: 4'b0000, ea: '{0, 0, 0, 0},
                dw: 4'b0000, da: '{0, 0, 0, 0}};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an erase pass, then re-plot the same boid.
    apply_reset();
    run_vec(vecs[0], "pre_abort");
    @(posedge clk); #1;
    in_valid = 1'b1; boid_id = 2'd0; x_in = {12'd30, 16'h0}; y_in = {11'd40, 16'h0};
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_we_before", m10k_we, 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_we_now", m10k_we, 0);
    chk("abort_ready_now", in_ready, 1);
    chk("abort_done_now", done, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1 chk("abort_ready_rel", in_ready, 1);
    run_vec(vecs[0], "replot");
    $display("abort: reset during erase, re-plot done");

    // Invalid id streamed back to back.
    @(posedge clk); #1;
    in_valid = 1'b1; boid_id = 2'd2; x_in = 28'h0010000; y_in = 27'h0010000;
    last = -1; npulse = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      chk("stream_we", m10k_we, 0);
      if (done) begin
        if (last >= 0) chk("stream_gap", cyc - last, 10);
        last = cyc; npulse++;
      end
    end
    chk("stream_pulses", (npulse >= 4), 1);
    $display("stream: id=2 done_pulses=%0d", npulse);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (12) @(posedge clk);
    run_vec(vecs[1], "after_stream");

    // Random traffic against the model.
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 2) == 0);
      boid_id  = 2'($urandom_range(0, 3));
      rx = pick(640);
      ry = pick(480);
      x_in = {12'(rx), 16'($urandom)};
      y_in = {11'(ry), 16'($urandom)};
      if (in_valid && in_ready)
        $display("rand: id=%0d x=%0d y=%0d", boid_id, rx, ry);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
